enemy_sprite_engine: RTL and testbench



---
 rtl/shooter_pkg.sv | 24 ++
 rtl/enemy_sprite_engine_if.sv | 20 ++
 rtl/enemy_motion_ctrl.sv | 144 ++++++++++++++
 rtl/enemy_sprite_engine.sv | 117 +++++++++++
 tb/tb_enemy_sprite_engine.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/shooter_pkg.sv
// Shared definitions for the shooter game sprite blocks.
//
// Contents:
//   SPRITE_SIZE   - edge length of a square sprite, in pixels
//   TRANSPARENT   - RGB332 colour key that the pixel mux treats as "no pixel"
//   enemy_state_t - enemy life cycle: ROAM, DYING, DEAD
//   dir_t         - horizontal travel direction: RIGHT, LEFT
package shooter_pkg;

  localparam int         SPRITE_SIZE = 16;
  localparam logic [7:0] TRANSPARENT = 8'hBB;

  typedef enum logic [1:0] {
    ROAM,
    DYING,
    DEAD
  } enemy_state_t;

  typedef enum logic {
    RIGHT,
    LEFT
  } dir_t;

endpackage

// File: rtl/enemy_sprite_engine_if.sv
// Address/data link between the enemy sprite engine and the 16x16 sprite ROM.
//
// Signals:
//   rom_row  - sprite row address (engine -> ROM)
//   rom_col  - sprite column address (engine -> ROM)
//   rom_data - RGB332 colour, valid one clock after the address (ROM -> engine)
//
// Modports:
//   master - the sprite engine (drives the address, consumes the colour)
//   slave  - the sprite ROM
interface enemy_sprite_engine_if;

  logic [3:0] rom_row;
  logic [3:0] rom_col;
  logic [7:0] rom_data;

  modport master (output rom_row, output rom_col, input rom_data);
  modport slave  (input rom_row, input rom_col, output rom_data);

endinterface

// File: rtl/enemy_motion_ctrl.sv
// Enemy life-cycle FSM plus position, direction and frame counters.
// Everything advances only on frame_tick, except hit which is taken
// immediately while roaming.
//
// Ports:
//   clk, reset_n        - clock, synchronous active-low reset
//   frame_tick          - one-cycle pulse per frame
//   hit                 - one-cycle bullet collision pulse
//   pos_x, pos_y        - top-left corner of the sprite
//   dir                 - current horizontal direction
//   visible             - sprite should be drawn this frame (blinks while dying)
//   alive               - high only while roaming
module enemy_motion_ctrl
  import shooter_pkg::*;
#(
  parameter logic [9:0] X_START        = 10'd32,
  parameter logic [9:0] Y_START        = 10'd32,
  parameter logic [9:0] X_MAX          = 10'd640,
  parameter logic [9:0] Y_MAX          = 10'd480,
  parameter logic [9:0] SPEED          = 10'd2,
  parameter logic [9:0] DROP           = 10'd16,
  parameter logic [5:0] DYING_FRAMES   = 6'd32,
  parameter logic [7:0] RESPAWN_FRAMES = 8'd120
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       hit,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output dir_t       dir,
  output logic       visible,
  output logic       alive
);

  // Limits kept at 11 bits so the edge comparisons cannot wrap.
  localparam logic [10:0] X_LIM = {1'b0, X_MAX} - 11'(SPRITE_SIZE);
  localparam logic [10:0] Y_LIM = {1'b0, Y_MAX} - 11'(SPRITE_SIZE);

  enemy_state_t state, state_n;
  logic [9:0]   pos_x_n, pos_y_n;
  dir_t         dir_n;
  logic [5:0]   dcnt, dcnt_n;
  logic [7:0]   rcnt, rcnt_n;
  logic [10:0]  nx, ny;
  logic         bump;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ROAM;
      pos_x <= X_START;
      pos_y <= Y_START;
      dir   <= RIGHT;
      dcnt  <= '0;
      rcnt  <= '0;
    end else begin
      state <= state_n;
      pos_x <= pos_x_n;
      pos_y <= pos_y_n;
      dir   <= dir_n;
      dcnt  <= dcnt_n;
      rcnt  <= rcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    pos_x_n = pos_x;
    pos_y_n = pos_y;
    dir_n   = dir;
    dcnt_n  = dcnt;
    rcnt_n  = rcnt;
    nx      = {1'b0, pos_x} + {1'b0, SPEED};
    ny      = {1'b0, pos_y} + {1'b0, DROP};
    bump    = 1'b0;
    visible = 1'b0;
    alive   = 1'b0;

    case (state)
      ROAM: begin
        visible = 1'b1;
        alive   = 1'b1;
        // A hit in the same cycle as a frame tick freezes the sprite in place.
        if (hit) begin
          state_n = DYING;
          dcnt_n  = '0;
        end else if (frame_tick) begin
          if (dir == RIGHT) begin
            if (nx > X_LIM) begin
              pos_x_n = X_LIM[9:0];
              dir_n   = LEFT;
              bump    = 1'b1;
            end else begin
              pos_x_n = nx[9:0];
            end
          end else begin
            // Checked before subtracting so pos_x never underflows.
            if (pos_x < SPEED) begin
              pos_x_n = '0;
              dir_n   = RIGHT;
              bump    = 1'b1;
            end else begin
              pos_x_n = pos_x - SPEED;
            end
          end
          if (bump) begin
            pos_y_n = (ny > Y_LIM) ? Y_START : ny[9:0];
          end
        end
      end

      DYING: begin
        // Bit 2 gives four frames off, four frames on.
        visible = dcnt[2];
        if (frame_tick) begin
          if (dcnt == DYING_FRAMES - 6'd1) begin
            state_n = DEAD;
            rcnt_n  = '0;
          end else begin
            dcnt_n = dcnt + 6'd1;
          end
        end
      end

      DEAD: begin
        if (frame_tick) begin
          if (rcnt == RESPAWN_FRAMES - 8'd1) begin
            state_n = ROAM;
            pos_x_n = X_START;
            pos_y_n = Y_START;
            dir_n   = RIGHT;
          end else begin
            rcnt_n = rcnt + 8'd1;
          end
        end
      end

      default: begin
        state_n = ROAM;
      end
    endcase
  end

endmodule

// File: rtl/enemy_sprite_engine.sv
// Enemy sprite engine: owns one enemy (via enemy_motion_ctrl) and renders it.
// For every VGA pixel it addresses the sprite ROM, waits one clock for the
// colour, applies the transparency key and registers enemy_on/rgb_out.
// Latency from x/y to enemy_on/rgb_out is two clocks.
//
// Ports:
//   clk, reset_n      - clock, synchronous active-low reset
//   x, y, video_on    - current pixel from vga_sync
//   frame_tick, hit   - per-frame pulse, bullet collision pulse
//   rom               - sprite ROM link (master side)
//   enemy_on, rgb_out - draw flag and RGB332 colour (0 when not drawn)
//   pos_x, pos_y      - sprite top-left corner
//   alive             - high while roaming
//
// Build option: define ENEMY_MIRROR_EN to mirror the sprite horizontally
// while it travels left.
module enemy_sprite_engine
  import shooter_pkg::*;
#(
  parameter logic [9:0] X_START        = 10'd32,
  parameter logic [9:0] Y_START        = 10'd32,
  parameter logic [9:0] X_MAX          = 10'd640,
  parameter logic [9:0] Y_MAX          = 10'd480,
  parameter logic [9:0] SPEED          = 10'd2,
  parameter logic [9:0] DROP           = 10'd16,
  parameter logic [5:0] DYING_FRAMES   = 6'd32,
  parameter logic [7:0] RESPAWN_FRAMES = 8'd120
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  input  logic                  video_on,
  input  logic                  frame_tick,
  input  logic                  hit,
  enemy_sprite_engine_if.master rom,
  output logic                  enemy_on,
  output logic [7:0]            rgb_out,
  output logic [9:0]            pos_x,
  output logic [9:0]            pos_y,
  output logic                  alive
);

  dir_t       dir;
  logic       visible;
  logic       in_box;
  logic [3:0] col_off;
  logic       in_box_d, video_on_d, visible_d;
  logic       draw;

  enemy_motion_ctrl #(
    .X_START        (X_START),
    .Y_START        (Y_START),
    .X_MAX          (X_MAX),
    .Y_MAX          (Y_MAX),
    .SPEED          (SPEED),
    .DROP           (DROP),
    .DYING_FRAMES   (DYING_FRAMES),
    .RESPAWN_FRAMES (RESPAWN_FRAMES)
  ) u_motion (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .hit        (hit),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .dir        (dir),
    .visible    (visible),
    .alive      (alive)
  );

  // Box test at 11 bits so pos+16 near the screen edge cannot wrap.
  assign in_box = ({1'b0, x} >= {1'b0, pos_x}) &&
                  ({1'b0, x} <  {1'b0, pos_x} + 11'(SPRITE_SIZE)) &&
                  ({1'b0, y} >= {1'b0, pos_y}) &&
                  ({1'b0, y} <  {1'b0, pos_y} + 11'(SPRITE_SIZE));

  // Only the low nibble of the offset addresses the ROM; outside the box
  // the address is don't-care.
  assign col_off     = x[3:0] - pos_x[3:0];
  assign rom.rom_row = y[3:0] - pos_y[3:0];

`ifdef ENEMY_MIRROR_EN
  assign rom.rom_col = (dir == LEFT) ? (4'd15 - col_off) : col_off;
`else
  logic unused_dir;
  assign unused_dir  = dir;
  assign rom.rom_col = col_off;
`endif

  // Stage 1: hold the qualifiers while the ROM looks up the colour.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      in_box_d   <= 1'b0;
      video_on_d <= 1'b0;
      visible_d  <= 1'b0;
    end else begin
      in_box_d   <= in_box;
      video_on_d <= video_on;
      visible_d  <= visible;
    end
  end

  assign draw = in_box_d & video_on_d & visible_d & (rom.rom_data != TRANSPARENT);

  // Stage 2: registered outputs to the pixel mux.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      enemy_on <= 1'b0;
      rgb_out  <= 8'h00;
    end else begin
      enemy_on <= draw;
      rgb_out  <= draw ? rom.rom_data : 8'h00;
    end
  end

endmodule

// File: tb/tb_enemy_sprite_engine.sv
// Directed testbench for enemy_sprite_engine: pixel pipeline, transparency,
// edge bounces, vertical wrap, dying blink, respawn and mid-DYING reset.
// Honours ENEMY_MIRROR_EN for the mirrored column check.
module tb_enemy_sprite_engine;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] x, y;
  logic       video_on;
  logic       frame_tick;
  logic       hit;
  logic [7:0] rom_fill;
  logic       enemy_on;
  logic [7:0] rgb_out;
  logic [9:0] pos_x, pos_y;
  logic       alive;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int check_cnt = 0;

`ifdef ENEMY_MIRROR_EN
  localparam logic [31:0] LEFT_COL = 32'd12;
`else
  localparam logic [31:0] LEFT_COL = 32'd3;
`endif

  always #5 clk = ~clk;

  enemy_sprite_engine_if rom_if ();

  // Synchronous ROM model: colour for the addressed pixel appears one clock later.
  always @(posedge clk) rom_if.rom_data <= rom_fill;

  enemy_sprite_engine dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .x          (x),
    .y          (y),
    .video_on   (video_on),
    .frame_tick (frame_tick),
    .hit        (hit),
    .rom        (rom_if.master),
    .enemy_on   (enemy_on),
    .rgb_out    (rgb_out),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .alive      (alive)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_cnt++;
    assert (observed === expected) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] px, input logic [9:0] py, input logic von, input logic [7:0] fill);
    x        = px;
    y        = py;
    video_on = von;
    rom_fill = fill;
  endtask

  task automatic waitPixel();
    repeat (2) @(negedge clk);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pulseHit();
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
  endtask

  // Ticks until pos_y moves (an edge bounce), bounded by a frame budget.
  task automatic waitBounce(input string tag);
    logic [9:0] start_y;
    logic       seen;
    start_y = pos_y;
    seen    = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick(1);
      if (pos_y != start_y) seen = 1'b1;
    end
    checkOutput(tag, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    reset_n    = 1'b0;
    frame_tick = 1'b0;
    hit        = 1'b0;
    applyStimulus(10'd0, 10'd0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);

    checkOutput("rst_pos_x", pos_x, 32'd32);
    checkOutput("rst_pos_y", pos_y, 32'd32);
    checkOutput("rst_alive", alive, 32'd1);
    checkOutput("rst_enemy_on", enemy_on, 32'd0);
    checkOutput("rst_rgb", rgb_out, 32'd0);
    reset_n = 1'b1;

    // Top-left pixel: nothing after one clock, colour after two.
    applyStimulus(10'd32, 10'd32, 1'b1, 8'hFC);
    @(negedge clk);
    checkOutput("latency_1clk", enemy_on, 32'd0);
    @(negedge clk);
    checkOutput("origin_on", enemy_on, 32'd1);
    checkOutput("origin_rgb", rgb_out, 32'hFC);

    applyStimulus(10'd48, 10'd32, 1'b1, 8'hFC);
    waitPixel();
    checkOutput("right_of_box_on", enemy_on, 32'd0);
    checkOutput("right_of_box_rgb", rgb_out, 32'd0);

    applyStimulus(10'd47, 10'd47, 1'b1, 8'h1F);
    waitPixel();
    checkOutput("corner_on", enemy_on, 32'd1);
    checkOutput("corner_rgb", rgb_out, 32'h1F);

    applyStimulus(10'd35, 10'd37, 1'b1, 8'hFC);
    #1;
    checkOutput("rom_row", rom_if.rom_row, 32'd5);
    checkOutput("rom_col_right", rom_if.rom_col, 32'd3);

    applyStimulus(10'd40, 10'd40, 1'b1, 8'hBB);
    waitPixel();
    checkOutput("transparent_on", enemy_on, 32'd0);
    checkOutput("transparent_rgb", rgb_out, 32'd0);

    applyStimulus(10'd40, 10'd40, 1'b0, 8'hFC);
    waitPixel();
    checkOutput("blank_on", enemy_on, 32'd0);

    // Right edge bounce.
    applyStimulus(10'd0, 10'd0, 1'b1, 8'hFC);
    waitBounce("right_bounce_seen");
    checkOutput("right_bounce_x", pos_x, 32'd624);
    checkOutput("right_bounce_y", pos_y, 32'd48);

    applyStimulus(10'd627, 10'd53, 1'b1, 8'hFC);
    #1;
    checkOutput("left_rom_row", rom_if.rom_row, 32'd5);
    checkOutput("left_rom_col", rom_if.rom_col, LEFT_COL);

    tick(1);
    checkOutput("after_bounce_x", pos_x, 32'd622);

    // Left edge bounce.
    waitBounce("left_bounce_seen");
    checkOutput("left_bounce_x", pos_x, 32'd0);
    checkOutput("left_bounce_y", pos_y, 32'd64);
    tick(1);
    checkOutput("after_left_x", pos_x, 32'd2);

    // Sweep down to the bottom row, then the next bounce wraps.
    for (int b = 0; b < 30 && pos_y != 10'd464; b++) waitBounce("sweep_bounce_seen");
    checkOutput("bottom_y", pos_y, 32'd464);
    waitBounce("wrap_seen");
    checkOutput("wrap_x", pos_x, 32'd0);
    checkOutput("wrap_y", pos_y, 32'd32);

    // Hit with frame_tick: hit wins, no move.
    hit        = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    hit        = 1'b0;
    frame_tick = 1'b0;
    checkOutput("hit_alive", alive, 32'd0);
    checkOutput("hit_pos_x", pos_x, 32'd0);
    checkOutput("hit_pos_y", pos_y, 32'd32);

    applyStimulus(10'd0, 10'd32, 1'b1, 8'hFC);
    waitPixel();
    checkOutput("blink_off_dcnt0", enemy_on, 32'd0);
    tick(4);
    waitPixel();
    checkOutput("blink_on_dcnt4", enemy_on, 32'd1);

    pulseHit();
    waitPixel();
    checkOutput("hit_ignored_dying_on", enemy_on, 32'd1);
    checkOutput("hit_ignored_dying_alive", alive, 32'd0);

    tick(27);
    waitPixel();
    checkOutput("dcnt31_on", enemy_on, 32'd1);
    tick(1);
    waitPixel();
    checkOutput("dead_on", enemy_on, 32'd0);
    checkOutput("dead_alive", alive, 32'd0);
    checkOutput("dead_pos_x", pos_x, 32'd0);

    pulseHit();
    tick(119);
    checkOutput("dead_119_alive", alive, 32'd0);
    tick(1);
    checkOutput("respawn_alive", alive, 32'd1);
    checkOutput("respawn_x", pos_x, 32'd32);
    checkOutput("respawn_y", pos_y, 32'd32);

    // Reset in the middle of DYING.
    tick(3);
    checkOutput("roam_again_x", pos_x, 32'd38);
    pulseHit();
    tick(4);
    applyStimulus(10'd38, 10'd32, 1'b1, 8'hFC);
    waitPixel();
    checkOutput("pre_reset_on", enemy_on, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_reset_alive", alive, 32'd1);
    checkOutput("mid_reset_on", enemy_on, 32'd0);
    checkOutput("mid_reset_x", pos_x, 32'd32);
    checkOutput("mid_reset_y", pos_y, 32'd32);
    reset_n = 1'b1;
    tick(1);
    checkOutput("post_reset_move_x", pos_x, 32'd34);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
